// File: rtl/ex_mem_buffer_if.sv
// ex_mem_buffer_if: groups the handshake, payload and exception signals between
// the EX stage, the EX/MEM buffer and the MEM stage.
//   slave  modport: the buffer's view (EX-side and control signals in, MEM-side out).
//   master modport: the driver's view (the opposite directions).
// Upstream:   in_valid/in_ready, alu_result, alu_zero, alu_overflow, alu_gtz,
//             in_trap_ovf, in_pc, in_rd, in_store_data, in_regwrite/memread/memwrite.
// Downstream: out_valid/out_ready, out_result, out_zero, out_gtz, out_pc, out_rd,
//             out_store_data, out_regwrite/memread/memwrite.
// Control:    flush, exc_ack, exc_pending, epc, exc_cause, occupancy.
interface ex_mem_buffer_if;
    // Upstream
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;
    logic        alu_gtz;
    logic        in_trap_ovf;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic [31:0] in_store_data;
    logic        in_regwrite;
    logic        in_memread;
    logic        in_memwrite;
    // Downstream
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_gtz;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [31:0] out_store_data;
    logic        out_regwrite;
    logic        out_memread;
    logic        out_memwrite;
    // Control / exception
    logic        flush;
    logic        exc_ack;
    logic        exc_pending;
    logic [31:0] epc;
    logic [4:0]  exc_cause;
    logic [1:0]  occupancy;

    modport slave (
        input  in_valid, alu_result, alu_zero, alu_overflow, alu_gtz, in_trap_ovf,
               in_pc, in_rd, in_store_data, in_regwrite, in_memread, in_memwrite,
               out_ready, flush, exc_ack,
        output in_ready, out_valid, out_result, out_zero, out_gtz, out_pc, out_rd,
               out_store_data, out_regwrite, out_memread, out_memwrite,
               exc_pending, epc, exc_cause, occupancy
    );

    modport master (
        output in_valid, alu_result, alu_zero, alu_overflow, alu_gtz, in_trap_ovf,
               in_pc, in_rd, in_store_data, in_regwrite, in_memread, in_memwrite,
               out_ready, flush, exc_ack,
        input  in_ready, out_valid, out_result, out_zero, out_gtz, out_pc, out_rd,
               out_store_data, out_regwrite, out_memread, out_memwrite,
               exc_pending, epc, exc_cause, occupancy
    );
endinterface

// File: rtl/ex_mem_buffer.sv
// ex_mem_buffer: 2-entry in-order EX/MEM pipeline buffer with overflow-trap capture.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; clears all entries and any pending exception
//   bus   - ex_mem_buffer_if.slave: EX-side beat in, MEM-side beat out, flush,
//           exception acknowledge/status and occupancy.
// All outputs come straight from flops, so they are all zero while rst_n is low and
// in_ready has no combinational path from out_ready or in_valid.
module ex_mem_buffer (
    input  logic            clk,
    input  logic            rst_n,
    ex_mem_buffer_if.slave  bus
);
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StHalf  = 2'd1,
        StFull  = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        gtz;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] store_data;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
    } entry_t;

    localparam logic [4:0] CauseOvf = 5'd12;

    state_e      state_q;
    logic        in_ready_q;
    entry_t      head_q;
    entry_t      tail_q;
    logic        exc_pending_q;
    logic [31:0] epc_q;
    logic [4:0]  exc_cause_q;

    logic        push;
    logic        pop;
    logic        store;
    logic        trap;
    entry_t      beat;

    assign push  = bus.in_valid & in_ready_q;
    assign pop   = (state_q != StEmpty) & bus.out_ready;
    // Beats are accepted while an exception is pending but never stored.
    assign store = push & ~exc_pending_q & ~bus.flush;
    // A flushed beat cannot raise an exception: flush leaves exception state alone.
    assign trap  = store & bus.alu_overflow & bus.in_trap_ovf;

    always_comb begin
        beat.result     = bus.alu_result;
        beat.zero       = bus.alu_zero;
        beat.gtz        = bus.alu_gtz;
        beat.pc         = bus.in_pc;
        beat.rd         = bus.in_rd;
        beat.store_data = bus.in_store_data;
        // A trapping instruction must not write back or touch memory.
        beat.regwrite   = bus.in_regwrite & ~trap;
        beat.memread    = bus.in_memread & ~trap;
        beat.memwrite   = bus.in_memwrite & ~trap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StEmpty;
            in_ready_q    <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            exc_pending_q <= 1'b0;
            epc_q         <= '0;
            exc_cause_q   <= '0;
        end else begin
            if (bus.flush) begin
                state_q    <= StEmpty;
                in_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    StEmpty: begin
                        in_ready_q <= 1'b1;
                        if (store) begin
                            head_q  <= beat;
                            state_q <= StHalf;
                        end
                    end
                    StHalf: begin
                        in_ready_q <= 1'b1;
                        if (store && pop) begin
                            // Old head leaves, new beat takes its place.
                            head_q <= beat;
                        end else if (store) begin
                            tail_q     <= beat;
                            state_q    <= StFull;
                            in_ready_q <= 1'b0;
                        end else if (pop) begin
                            state_q <= StEmpty;
                        end
                    end
                    StFull: begin
                        // in_ready is low here, so no push can coincide with the pop.
                        if (pop) begin
                            head_q     <= tail_q;
                            state_q    <= StHalf;
                            in_ready_q <= 1'b1;
                        end else begin
                            in_ready_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q    <= StEmpty;
                        in_ready_q <= 1'b1;
                    end
                endcase
            end

            // trap implies no exception was pending, so it cannot race a real ack.
            if (trap) begin
                exc_pending_q <= 1'b1;
                epc_q         <= bus.in_pc;
                exc_cause_q   <= CauseOvf;
            end else if (bus.exc_ack) begin
                exc_pending_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = (state_q != StEmpty);
    assign bus.occupancy      = state_q;
    assign bus.out_result     = head_q.result;
    assign bus.out_zero       = head_q.zero;
    assign bus.out_gtz        = head_q.gtz;
    assign bus.out_pc         = head_q.pc;
    assign bus.out_rd         = head_q.rd;
    assign bus.out_store_data = head_q.store_data;
    assign bus.out_regwrite   = head_q.regwrite;
    assign bus.out_memread    = head_q.memread;
    assign bus.out_memwrite   = head_q.memwrite;
    assign bus.exc_pending    = exc_pending_q;
    assign bus.epc            = epc_q;
    assign bus.exc_cause      = exc_cause_q;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb_ex_mem_buffer: directed scenarios plus randomized traffic for ex_mem_buffer,
// compared every cycle against a queue-based reference model.
module tb_ex_mem_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ex_mem_buffer_if bus ();

    ex_mem_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        gtz;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] store_data;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
    } entry_t;

    // Reference model state
    entry_t      q[$];
    logic        m_pending;
    logic [31:0] m_epc;
    logic [4:0]  m_cause;
    logic        m_ready;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic entry_t dut_head();
        return {bus.out_result, bus.out_zero, bus.out_gtz, bus.out_pc, bus.out_rd,
                bus.out_store_data, bus.out_regwrite, bus.out_memread, bus.out_memwrite};
    endfunction

    function automatic entry_t in_beat();
        return {bus.alu_result, bus.alu_zero, bus.alu_gtz, bus.in_pc, bus.in_rd,
                bus.in_store_data, bus.in_regwrite, bus.in_memread, bus.in_memwrite};
    endfunction

    task automatic model_reset();
        q.delete();
        m_pending = 1'b0;
        m_epc     = '0;
        m_cause   = '0;
        m_ready   = 1'b0;
    endtask

    // Applies the rules at one rising edge, using the inputs held across it.
    task automatic model_update();
        logic   push;
        logic   pop;
        logic   trap;
        entry_t b;
        if (!rst_n) begin
            model_reset();
            return;
        end
        push = bus.in_valid && m_ready;
        pop  = (q.size() > 0) && bus.out_ready;
        trap = push && bus.alu_overflow && bus.in_trap_ovf && !m_pending && !bus.flush;
        b    = in_beat();
        if (bus.flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push && !m_pending) begin
                if (trap) begin
                    b.regwrite = 1'b0;
                    b.memread  = 1'b0;
                    b.memwrite = 1'b0;
                end
                q.push_back(b);
            end
        end
        if (bus.exc_ack) m_pending = 1'b0;
        if (trap) begin
            m_pending = 1'b1;
            m_epc     = bus.in_pc;
            m_cause   = 5'd12;
        end
        m_ready = (q.size() < 2);
    endtask

    task automatic compare_all();
        check_eq("in_ready", 128'(bus.in_ready), 128'(m_ready));
        check_eq("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
        check_eq("occupancy", 128'(bus.occupancy), 128'(q.size()));
        check_eq("exc_pending", 128'(bus.exc_pending), 128'(m_pending));
        check_eq("epc", 128'(bus.epc), 128'(m_epc));
        check_eq("exc_cause", 128'(bus.exc_cause), 128'(m_cause));
        if (q.size() > 0) check_eq("head", 128'(dut_head()), 128'(q[0]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.in_valid      = 1'b0;
        bus.alu_result    = '0;
        bus.alu_zero      = 1'b0;
        bus.alu_overflow  = 1'b0;
        bus.alu_gtz       = 1'b0;
        bus.in_trap_ovf   = 1'b0;
        bus.in_pc         = '0;
        bus.in_rd         = '0;
        bus.in_store_data = '0;
        bus.in_regwrite   = 1'b0;
        bus.in_memread    = 1'b0;
        bus.in_memwrite   = 1'b0;
        bus.out_ready     = 1'b0;
        bus.flush         = 1'b0;
        bus.exc_ack       = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] res, input logic [31:0] pc, input logic ovf,
                              input logic trp, input logic rw);
        bus.in_valid      = 1'b1;
        bus.alu_result    = res;
        bus.alu_zero      = (res == 32'd0);
        bus.alu_gtz       = !res[31] && (res != 32'd0);
        bus.alu_overflow  = ovf;
        bus.in_trap_ovf   = trp;
        bus.in_pc         = pc;
        bus.in_rd         = 5'($urandom);
        bus.in_store_data = $urandom;
        bus.in_regwrite   = rw;
        bus.in_memread    = 1'($urandom_range(0, 1));
        bus.in_memwrite   = 1'($urandom_range(0, 1));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_in_ready"}, 128'(bus.in_ready), 128'(0));
        check_eq({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
        check_eq({tag, "_occupancy"}, 128'(bus.occupancy), 128'(0));
        check_eq({tag, "_exc_pending"}, 128'(bus.exc_pending), 128'(0));
        check_eq({tag, "_epc"}, 128'(bus.epc), 128'(0));
        check_eq({tag, "_exc_cause"}, 128'(bus.exc_cause), 128'(0));
        check_eq({tag, "_payload"}, 128'(dut_head()), 128'(0));
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("ready_after_reset", 128'(bus.in_ready), 128'(1));

        // Single beat
        bus.out_ready = 1'b1;
        drive_beat(32'h0000_0010, 32'h0040_0000, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("single_valid", 128'(bus.out_valid), 128'(1));
        check_eq("single_result", 128'(bus.out_result), 128'(32'h10));
        bus.in_valid = 1'b0;
        tick();
        check_eq("single_valid_gone", 128'(bus.out_valid), 128'(0));
        check_eq("single_occ", 128'(bus.occupancy), 128'(0));

        // Backpressure: A, B accepted, C held off until space frees
        bus.out_ready = 1'b0;
        drive_beat(32'h0000_00AA, 32'h0040_0100, 1'b0, 1'b0, 1'b1);
        tick();
        drive_beat(32'h0000_00BB, 32'h0040_0104, 1'b0, 1'b0, 1'b1);
        tick();
        drive_beat(32'h0000_00CC, 32'h0040_0108, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("bp_ready", 128'(bus.in_ready), 128'(0));
        check_eq("bp_occ", 128'(bus.occupancy), 128'(2));
        check_eq("bp_head_a", 128'(bus.out_result), 128'(32'hAA));
        bus.out_ready = 1'b1;
        tick();
        check_eq("bp_head_b", 128'(bus.out_result), 128'(32'hBB));
        tick();
        check_eq("bp_head_c", 128'(bus.out_result), 128'(32'hCC));
        check_eq("bp_occ_c", 128'(bus.occupancy), 128'(1));
        bus.in_valid = 1'b0;
        tick();

        // Overflow trap
        bus.out_ready = 1'b0;
        drive_beat(32'h8000_0000, 32'h0040_0008, 1'b1, 1'b1, 1'b1);
        tick();
        check_eq("trap_regwrite", 128'(bus.out_regwrite), 128'(0));
        check_eq("trap_pending", 128'(bus.exc_pending), 128'(1));
        check_eq("trap_epc", 128'(bus.epc), 128'(32'h0040_0008));
        check_eq("trap_cause", 128'(bus.exc_cause), 128'(12));
        drive_beat(32'h0000_1234, 32'h0040_000C, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("trap_discard_occ", 128'(bus.occupancy), 128'(1));
        check_eq("trap_epc_kept", 128'(bus.epc), 128'(32'h0040_0008));
        bus.exc_ack = 1'b1;
        tick();
        check_eq("ack_pending", 128'(bus.exc_pending), 128'(0));
        check_eq("ack_discard_occ", 128'(bus.occupancy), 128'(1));
        bus.exc_ack   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();

        // Non-trapping overflow
        drive_beat(32'h7FFF_FFFF, 32'h0040_0010, 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("nontrap_valid", 128'(bus.out_valid), 128'(1));
        check_eq("nontrap_regwrite", 128'(bus.out_regwrite), 128'(1));
        check_eq("nontrap_pending", 128'(bus.exc_pending), 128'(0));
        bus.in_valid = 1'b0;
        tick();

        // Flush when FULL, exception from an earlier beat retained
        bus.out_ready = 1'b0;
        drive_beat(32'h0000_0011, 32'h0040_0020, 1'b0, 1'b0, 1'b1);
        tick();
        drive_beat(32'h8000_0001, 32'h0040_0024, 1'b1, 1'b1, 1'b1);
        tick();
        check_eq("flush_pre_occ", 128'(bus.occupancy), 128'(2));
        bus.flush = 1'b1;
        drive_beat(32'h0000_0022, 32'h0040_0028, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("flush_occ", 128'(bus.occupancy), 128'(0));
        check_eq("flush_valid", 128'(bus.out_valid), 128'(0));
        check_eq("flush_pending", 128'(bus.exc_pending), 128'(1));
        check_eq("flush_epc", 128'(bus.epc), 128'(32'h0040_0024));
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.exc_ack  = 1'b1;
        tick();
        bus.exc_ack = 1'b0;

        // Asynchronous reset while FULL with an exception pending
        drive_beat(32'h0000_0033, 32'h0040_0030, 1'b0, 1'b0, 1'b1);
        tick();
        drive_beat(32'h8000_0002, 32'h0040_0034, 1'b1, 1'b1, 1'b1);
        tick();
        check_eq("rst_pre_occ", 128'(bus.occupancy), 128'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("ready_after_release", 128'(bus.in_ready), 128'(1));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.in_valid      = ($urandom_range(0, 9) < 7);
            bus.alu_result    = $urandom;
            bus.alu_zero      = 1'($urandom_range(0, 1));
            bus.alu_gtz       = 1'($urandom_range(0, 1));
            bus.alu_overflow  = ($urandom_range(0, 3) == 0);
            bus.in_trap_ovf   = 1'($urandom_range(0, 1));
            bus.in_pc         = $urandom;
            bus.in_rd         = 5'($urandom);
            bus.in_store_data = $urandom;
            bus.in_regwrite   = 1'($urandom_range(0, 1));
            bus.in_memread    = 1'($urandom_range(0, 1));
            bus.in_memwrite   = 1'($urandom_range(0, 1));
            bus.out_ready     = ($urandom_range(0, 9) < 6);
            bus.flush         = ($urandom_range(0, 19) == 0);
            bus.exc_ack       = m_pending && ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
